line_clear_sequencer: RTL and testbench

Sits between piece locking and rendering. Takes each post-lock 200-cell board, drives it into the row elimination stage, and feeds back the single-row-removed result until no full row remains. Counts the rows cleared in the batch and updates the running score and line total. Presents the settled board downstream. Holds the authoritative static-board register.

---
 rtl/line_clear_sequencer_pkg.sv | 27 ++
 rtl/line_clear_sequencer_points.sv | 25 ++
 rtl/line_clear_sequencer.sv | 124 ++++++++++++
 tb/tb_line_clear_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_sequencer_pkg.sv
// line_clear_sequencer_pkg
// Shared definitions for the line-clear sequencer: board geometry, the board
// vector type, FSM state encoding and the per-batch scoring constants.
package line_clear_sequencer_pkg;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;

  // Cell (r,c) lives at bit r*COLS+c; row 0 is the bottom row.
  typedef logic [0:CELLS-1] board_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    LOAD,
    REPORT
  } state_t;

  // Widest award is 800, so ten bits cover every batch result.
  localparam int POINTS_W = 10;
  localparam logic [POINTS_W-1:0] POINTS_1 = 10'd100;
  localparam logic [POINTS_W-1:0] POINTS_2 = 10'd300;
  localparam logic [POINTS_W-1:0] POINTS_3 = 10'd500;
  localparam logic [POINTS_W-1:0] POINTS_4 = 10'd800;

endpackage

// File: rtl/line_clear_sequencer_points.sv
// line_points
// Combinational mapping from rows cleared in one batch to points awarded.
// Any batch of four or more rows earns the four-row award.
// Ports:
//   count   rows cleared in the batch (0..20)
//   points  points awarded for that batch
module line_points
  import line_clear_sequencer_pkg::*;
(
  input  logic [4:0]          count,
  output logic [POINTS_W-1:0] points
);

  always_comb begin
    points = '0;
    case (count)
      5'd0:    points = '0;
      5'd1:    points = POINTS_1;
      5'd2:    points = POINTS_2;
      5'd3:    points = POINTS_3;
      default: points = POINTS_4;
    endcase
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
// Accepts a freshly locked board, loops it through the external row
// elimination stage until no full row remains, then reports the number of
// rows cleared and updates the running score and line total.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   lock_valid     a locked board is offered on lock_board
//   lock_board     board with the landed piece merged
//   lock_ready     high only while idle
//   elim_board     board presented to the elimination stage
//   elim_flag      elimination stage reports a full row in elim_board
//   elim_result    elimination stage output, lowest full row removed
//   board          current board register
//   busy           high whenever not idle
//   done           one-cycle batch-finished pulse
//   lines_cleared  rows cleared in the last batch
//   score          saturating running score
//   total_lines    saturating running line total
//   clear_score    zero score and total_lines on the next edge
module line_clear_sequencer #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int SCORE_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lock_valid,
  input  logic [0:ROWS*COLS-1]   lock_board,
  output logic                   lock_ready,
  output logic [0:ROWS*COLS-1]   elim_board,
  input  logic                   elim_flag,
  input  logic [0:ROWS*COLS-1]   elim_result,
  output logic [0:ROWS*COLS-1]   board,
  output logic                   busy,
  output logic                   done,
  output logic [4:0]             lines_cleared,
  output logic [SCORE_W-1:0]     score,
  output logic [15:0]            total_lines,
  input  logic                   clear_score
);

  import line_clear_sequencer_pkg::*;

  state_t                state, next_state;
  logic [4:0]            batch_cnt;
  logic [POINTS_W-1:0]   points;
  logic                  finish;
  logic [SCORE_W:0]      score_sum;
  logic [16:0]           total_sum;
  logic [SCORE_W-1:0]    score_next;
  logic [15:0]           total_next;

  line_points u_points (
    .count  (batch_cnt),
    .points (points)
  );

  assign elim_board = board;
  assign lock_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // The batch ends on the EVAL edge where the stage sees no full row.
  assign finish = (state == EVAL) && !elim_flag;

  // One extra carry bit on each sum detects overflow for saturation.
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(points);
  assign total_sum  = {1'b0, total_lines} + {12'd0, batch_cnt};
  assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lock_valid) next_state = EVAL;
      EVAL:    next_state = elim_flag ? LOAD : REPORT;
      LOAD:    next_state = EVAL;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Board, batch counter and reporting registers. clear_score takes
  // priority over the end-of-batch update so a coincident clear discards
  // that batch's points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board         <= '0;
      batch_cnt     <= '0;
      done          <= 1'b0;
      lines_cleared <= '0;
      score         <= '0;
      total_lines   <= '0;
    end else begin
      done <= finish;
      case (state)
        IDLE: begin
          if (lock_valid) begin
            board     <= lock_board;
            batch_cnt <= '0;
          end
        end
        LOAD: begin
          board <= elim_result;
          if (batch_cnt != 5'(ROWS)) batch_cnt <= batch_cnt + 5'd1;
        end
        default: ;
      endcase
      if (finish) lines_cleared <= batch_cnt;
      if (clear_score) begin
        score       <= '0;
        total_lines <= '0;
      end else if (finish) begin
        score       <= score_next;
        total_lines <= total_next;
      end
    end
  end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb_line_clear_sequencer
// Directed bench for line_clear_sequencer with a behavioural model of the
// row elimination stage alongside it.
module tb_line_clear_sequencer;
  import line_clear_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock_valid = 1'b0;
  board_t      lock_board = '0;
  logic        lock_ready;
  board_t      elim_board;
  logic        elim_flag;
  board_t      elim_result = '0;
  board_t      board;
  logic        busy;
  logic        done;
  logic [4:0]  lines_cleared;
  logic [19:0] score;
  logic [15:0] total_lines;
  logic        clear_score = 1'b0;

  int compareCount = 0;
  int failCount = 0;

  line_clear_sequencer #(.ROWS(20), .COLS(10), .SCORE_W(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock_valid    (lock_valid),
    .lock_board    (lock_board),
    .lock_ready    (lock_ready),
    .elim_board    (elim_board),
    .elim_flag     (elim_flag),
    .elim_result   (elim_result),
    .board         (board),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score         (score),
    .total_lines   (total_lines),
    .clear_score   (clear_score)
  );

  always #5 clk = ~clk;

  function automatic logic rowFull(input board_t b, input int r);
    return &b[r*COLS +: COLS];
  endfunction

  function automatic logic anyFull(input board_t b);
    logic f = 1'b0;
    for (int r = 0; r < ROWS; r++) if (rowFull(b, r)) f = 1'b1;
    return f;
  endfunction

  function automatic board_t removeLowest(input board_t b);
    board_t o = b;
    int low = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (rowFull(b, r)) low = r;
    if (low >= 0) begin
      for (int i = low; i < ROWS - 1; i++) o[i*COLS +: COLS] = b[(i+1)*COLS +: COLS];
      o[(ROWS-1)*COLS +: COLS] = '0;
    end
    return o;
  endfunction

  function automatic board_t fullRows(input int n);
    board_t b = '0;
    for (int r = 0; r < n; r++) b[r*COLS +: COLS] = '1;
    return b;
  endfunction

  // Elimination stage model: combinational flag, registered result.
  assign elim_flag = anyFull(elim_board);
  always_ff @(posedge clk) elim_result <= removeLowest(elim_board);

  task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one board, returns the cycle (counted from the accept edge) in
  // which done was seen, or the bound if it never came.
  task automatic applyStimulus(input board_t b, input logic clr, output int doneCycle);
    @(negedge clk);
    lock_board  = b;
    lock_valid  = 1'b1;
    clear_score = clr;
    @(posedge clk);
    @(negedge clk);
    lock_valid = 1'b0;
    doneCycle = 1;
    while (!done && doneCycle < 100) begin
      @(negedge clk);
      doneCycle++;
    end
  endtask

  board_t b;
  board_t expB;
  int     cyc;
  int     seenDone;

  initial begin
    // Reset state
    #3;
    checkOutput("rst_lock_ready", 200'(lock_ready), 200'(1));
    checkOutput("rst_busy", 200'(busy), 200'(0));
    checkOutput("rst_done", 200'(done), 200'(0));
    checkOutput("rst_score", 200'(score), 200'(0));
    checkOutput("rst_total", 200'(total_lines), 200'(0));
    checkOutput("rst_lines", 200'(lines_cleared), 200'(0));
    checkOutput("rst_board", 200'(board), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // No full rows: done in cycle 2, board untouched
    b = '0;
    b[0] = 1'b1;
    b[5*COLS+3] = 1'b1;
    applyStimulus(b, 1'b0, cyc);
    checkOutput("k0_cycle", 200'(cyc), 200'(2));
    checkOutput("k0_lines", 200'(lines_cleared), 200'(0));
    checkOutput("k0_score", 200'(score), 200'(0));
    checkOutput("k0_board", 200'(board), 200'(b));
    checkOutput("k0_busy_at_done", 200'(busy), 200'(1));
    @(negedge clk);
    checkOutput("k0_ready_after", 200'(lock_ready), 200'(1));
    checkOutput("k0_done_low", 200'(done), 200'(0));

    // Row 0 full plus a cell at (1,4)
    b = fullRows(1);
    b[1*COLS+4] = 1'b1;
    expB = '0;
    expB[4] = 1'b1;
    applyStimulus(b, 1'b0, cyc);
    checkOutput("k1_cycle", 200'(cyc), 200'(4));
    checkOutput("k1_lines", 200'(lines_cleared), 200'(1));
    checkOutput("k1_score", 200'(score), 200'(100));
    checkOutput("k1_total", 200'(total_lines), 200'(1));
    checkOutput("k1_board", 200'(board), 200'(expB));

    // Clear while idle, then a four-row batch
    @(negedge clk);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    checkOutput("idle_clear_score", 200'(score), 200'(0));
    checkOutput("idle_clear_total", 200'(total_lines), 200'(0));
    applyStimulus(fullRows(4), 1'b0, cyc);
    checkOutput("k4_cycle", 200'(cyc), 200'(10));
    checkOutput("k4_lines", 200'(lines_cleared), 200'(4));
    checkOutput("k4_score", 200'(score), 200'(800));
    checkOutput("k4_total", 200'(total_lines), 200'(4));
    checkOutput("k4_board", 200'(board), 200'(0));

    // Three two-row batches from a cleared score
    @(negedge clk);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    b = fullRows(2);
    b[2*COLS+7] = 1'b1;
    expB = '0;
    expB[7] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b, 1'b0, cyc);
      checkOutput("k2_cycle", 200'(cyc), 200'(6));
      checkOutput("k2_board", 200'(board), 200'(expB));
    end
    checkOutput("k2x3_score", 200'(score), 200'(900));
    checkOutput("k2x3_total", 200'(total_lines), 200'(6));
    checkOutput("k2x3_lines", 200'(lines_cleared), 200'(2));
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    checkOutput("report_clear_score", 200'(score), 200'(0));
    checkOutput("report_clear_total", 200'(total_lines), 200'(0));
    checkOutput("report_clear_lines", 200'(lines_cleared), 200'(2));

    // Clear held across the finishing edge discards the batch points
    b = fullRows(1);
    applyStimulus(b, 1'b1, cyc);
    checkOutput("clr_win_score", 200'(score), 200'(0));
    checkOutput("clr_win_total", 200'(total_lines), 200'(0));
    checkOutput("clr_win_lines", 200'(lines_cleared), 200'(1));
    clear_score = 1'b0;

    // Drive score toward the top: 1310*800 + 500 = 1048500, then +100 saturates
    seenDone = 0;
    for (int i = 0; i < 1310; i++) begin
      applyStimulus(fullRows(4), 1'b0, cyc);
      if (cyc != 10) seenDone++;
    end
    checkOutput("sat_loop_timing", 200'(seenDone), 200'(0));
    checkOutput("pre_sat_score", 200'(score), 200'(1048000));
    applyStimulus(fullRows(3), 1'b0, cyc);
    checkOutput("pre_sat_score3", 200'(score), 200'(1048500));
    applyStimulus(fullRows(1), 1'b0, cyc);
    checkOutput("sat_score", 200'(score), 200'(1048575));
    checkOutput("sat_total", 200'(total_lines), 200'(5244));

    // Reset asserted during LOAD of a two-row batch
    @(negedge clk);
    lock_board = fullRows(2);
    lock_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lock_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", 200'(busy), 200'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_board", 200'(board), 200'(0));
    checkOutput("mid_rst_score", 200'(score), 200'(0));
    checkOutput("mid_rst_total", 200'(total_lines), 200'(0));
    checkOutput("mid_rst_ready", 200'(lock_ready), 200'(1));
    checkOutput("mid_rst_busy", 200'(busy), 200'(0));
    checkOutput("mid_rst_done", 200'(done), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seenDone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seenDone++;
    end
    checkOutput("mid_rst_no_done", 200'(seenDone), 200'(0));
    checkOutput("mid_rst_idle", 200'(lock_ready), 200'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
